// File: rtl/dma_cmd_gen.sv
// dma_cmd_gen: splits one (base, length) request into MAX_CHUNK-sized MM2S commands, one per completion interrupt.
// Optional per-command watchdog enabled by defining DMA_CMD_TIMEOUT_EN.
module dma_cmd_gen #(
    parameter logic [31:0] MAX_CHUNK      = 32'h0000_4000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] total_bytes,
    input  logic        introut,
    output logic [63:0] DMA_CMD,
    output logic        DMA_Valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] cmd_count,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] addr, remain, addr_nx, remain_nx, chunk, chunk_nx;
    logic introut_d, rise, accept, tmo;
    assign rise     = introut & ~introut_d;
    assign accept   = (state == IDLE) && start;
    assign chunk    = (remain > MAX_CHUNK) ? MAX_CHUNK : remain;
    assign chunk_nx = (remain_nx > MAX_CHUNK) ? MAX_CHUNK : remain_nx;
`ifdef DMA_CMD_TIMEOUT_EN
    logic [31:0] tcnt;
    assign tmo = (state == WAIT) && !rise && (tcnt == TIMEOUT_CYCLES - 32'd1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt        <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= (state == WAIT) ? tcnt + 32'd1 : 32'd0;
            timeout_err <= accept ? 1'b0 : (timeout_err | tmo);
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif
    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        remain_nx = remain;
        case (state)
            IDLE: if (start) begin
                addr_nx   = base_addr;
                remain_nx = {total_bytes[31:4], 4'b0};
                state_nx  = (remain_nx == 32'd0) ? DONE : ISSUE;
            end
            ISSUE: state_nx = WAIT;
            WAIT: if (rise) begin
                addr_nx   = addr + chunk;
                remain_nx = remain - chunk;
                state_nx  = (remain_nx != 32'd0) ? ISSUE : DONE;
            end else if (tmo) begin
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Strobes are registered on state entry, so they coincide with the ISSUE/DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= 32'd0;
            remain    <= 32'd0;
            introut_d <= 1'b0;
            DMA_CMD   <= 64'd0;
            DMA_Valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_count <= 16'd0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remain    <= remain_nx;
            introut_d <= introut;
            DMA_Valid <= state_nx == ISSUE;
            done      <= state_nx == DONE;
            busy      <= state_nx != IDLE;
            if (state_nx == ISSUE) DMA_CMD <= {addr_nx, chunk_nx};
            if (accept) cmd_count <= {15'd0, state_nx == ISSUE};
            else if (state_nx == ISSUE) cmd_count <= cmd_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_dma_cmd_gen.sv
// tb_dma_cmd_gen: directed and randomized requests checked against a command-list model of the splitter.
module tb_dma_cmd_gen;
    localparam logic [31:0] MAXC = 32'h0000_4000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [31:0] total_bytes = 32'd0;
    logic        introut = 1'b0;
    logic [63:0] DMA_CMD;
    logic        DMA_Valid, busy, done, timeout_err;
    logic [15:0] cmd_count;
    int checks = 0;
    int failures = 0;

    dma_cmd_gen #(.MAX_CHUNK(MAXC), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .total_bytes(total_bytes), .introut(introut), .DMA_CMD(DMA_CMD),
        .DMA_Valid(DMA_Valid), .busy(busy), .done(done),
        .cmd_count(cmd_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd"}, DMA_CMD, 64'd0);
        chk({tag, "_valid"}, DMA_Valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_count"}, cmd_count, 16'd0);
        chk({tag, "_tmo"}, timeout_err, 1'b0);
    endtask

    // Expected command list: walk the request in MAX_CHUNK steps over the 16-byte-truncated length.
    task automatic run_req(input logic [31:0] b, input logic [31:0] t);
        logic [63:0] q[$];
        logic [31:0] a, r, c;
        int hold;
        a = b;
        r = t & ~32'hF;
        while (r != 0) begin
            c = (r > MAXC) ? MAXC : r;
            q.push_back({a, c});
            a = a + c;
            r = r - c;
        end
        @(negedge clk);
        start = 1'b1; base_addr = b; total_bytes = t;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; total_bytes = $urandom;
        for (int i = 0; i < q.size(); i++) begin
            chk("cmd_valid", DMA_Valid, 1'b1);
            chk("cmd_value", DMA_CMD, q[i]);
            chk("cmd_count", cmd_count, 16'(i + 1));
            chk("cmd_busy", busy, 1'b1);
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                chk("wait_valid_low", DMA_Valid, 1'b0);
                chk("wait_done_low", done, 1'b0);
                start = 1'($urandom_range(0, 1)); base_addr = $urandom; total_bytes = $urandom;
            end
            introut = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("gap_valid_low", DMA_Valid, 1'b0);
                chk("gap_done_low", done, 1'b0);
                start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            introut = 1'b1;
            @(negedge clk);
        end
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b1);
        chk("end_valid", DMA_Valid, 1'b0);
        chk("end_count", cmd_count, 16'(q.size()));
        chk("end_tmo", timeout_err, 1'b0);
        start = 1'b1; base_addr = $urandom; total_bytes = 32'h100;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_valid", DMA_Valid, 1'b0);
        @(negedge clk);
        chk("ignored_start_valid", DMA_Valid, 1'b0);
        chk("ignored_start_busy", busy, 1'b0);
    endtask

    initial begin
        bit done_seen;
        int seen;
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;
        run_req(32'h1000_0000, 32'h0000_8000);
        run_req(32'h2000_0000, 32'h0000_4010);
        run_req(32'h3000_0000, 32'h0000_000F);
        run_req(32'hFFFF_C000, 32'h0000_8000);
        repeat (8) run_req($urandom, $urandom_range(0, 32'h0000_C01F));

        // Asynchronous reset while waiting on the first command's interrupt.
        introut = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h4000_0000; total_bytes = 32'h8000;
        @(negedge clk);
        start = 1'b0;
        chk("rst_pre_valid", DMA_Valid, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_idle_outputs("rst_mid");
        introut = 1'b1;
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | done | DMA_Valid | busy;
        end
        chk("rst_quiet", done_seen, 1'b0);
        introut = 1'b0;
        rst = 1'b1;
        run_req(32'h5000_0010, 32'h0000_4010);

        // Watchdog: introut never rises for the first command.
        introut = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h6000_0000; total_bytes = 32'h8000;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_first_valid", DMA_Valid, 1'b1);
        seen = -1;
        done_seen = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (done && seen < 0) seen = k;
            done_seen = done_seen | done;
        end
`ifdef DMA_CMD_TIMEOUT_EN
        chk("tmo_done_cycle", 64'(seen), 64'd101);
        chk("tmo_flag", timeout_err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        run_req(32'h7000_0000, 32'h0000_4000);
`else
        chk("notmo_no_done", done_seen, 1'b0);
        chk("notmo_busy", busy, 1'b1);
        chk("notmo_flag", timeout_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_req(32'h7000_0000, 32'h0000_4000);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
